pe_meas_sched: RTL and testbench
================================

// Module: pe_meas_sched
// PURPOSE
//  Sequences one batch of N_SIGMA sigma points (160-bit, 5 x Q16.16) through a single pe_meas_proc.
//  Returns the N_SIGMA 64-bit measurements {range, bearing} downstream in issue order, each tagged with its index.
//  The PE has fixed latency and no backpressure, so issue is credit-limited against the result buffer.
//  After any reset, a flush window discards stale PE results.
// PARAMETERS
//  N_SIGMA     11  sigma points per batch (2n+1, n=5)
//  PE_LATENCY  24  cycles from pe_state_valid sample to matching pe_meas_valid; fixed
//  BUF_DEPTH   16  result FIFO entries; power of 2, >= 2
// PORTS
//  clk             in   1    clock
//  rst             in   1    synchronous reset, active-high
//  start           in   1    batch start pulse; ignored unless IDLE
//  busy            out  1    high in every state except IDLE
//  done            out  1    1-cycle pulse after the last measurement is accepted downstream
//  err             out  1    sticky: unexpected PE result; cleared only by rst
//  sp_state        in   160  sigma point from upstream
//  sp_valid        in   1    upstream valid
//  sp_ready        out  1    upstream ready
//  pe_en_clk       out  1    PE clock enable
//  pe_state        out  160  state to PE (registered)
//  pe_state_valid  out  1    PE input valid (registered)
//  pe_meas         in   64   PE result {range[63:32], bearing[31:0]}
//  pe_meas_valid   in   1    PE result valid
//  m_meas          out  64   measurement out (FIFO head)
//  m_idx           out  $clog2(N_SIGMA)  sigma-point index 0..N_SIGMA-1 of m_meas
//  m_valid         out  1    downstream valid
//  m_ready         in   1    downstream ready
// BEHAVIOUR
//  Reset values
//   - All registered outputs 0, except pe_en_clk = 1.
//   - FSM enters FLUSH; all counters and the FIFO are cleared.
//   - rst mid-batch abandons the batch. No done is issued. PE in-flight results are dropped in FLUSH.
//  FSM
//   - FLUSH: runs PE_LATENCY+2 cycles with pe_en_clk=1 and pe_meas_valid ignored, then goes to IDLE.
//   - IDLE: pe_en_clk=0, sp_ready=0. start -> ISSUE; issue_cnt, rx_cnt and tx_cnt cleared.
//   - ISSUE: pe_en_clk=1. Upstream transfer occurs when sp_valid && sp_ready.
//       sp_ready = (issue_cnt < N_SIGMA) && (inflight + fifo_cnt < BUF_DEPTH).
//       inflight = issue_cnt - rx_cnt.
//       On transfer: the next cycle drives pe_state=sp_state and pe_state_valid=1, and issue_cnt increments.
//       Without a transfer, pe_state_valid=0 and pe_state holds its value.
//       When issue_cnt reaches N_SIGMA -> DRAIN.
//   - DRAIN: sp_ready=0, pe_en_clk=1. When tx_cnt == N_SIGMA -> DONE.
//   - DONE: done=1 for one cycle, then IDLE.
//  Results
//   - In ISSUE/DRAIN, each pe_meas_valid pushes {pe_meas, rx_cnt} into the FIFO; rx_cnt increments.
//   - The credit rule guarantees the FIFO never overflows.
//   - err is set (and the result dropped) when pe_meas_valid arrives in IDLE or DONE, when rx_cnt == issue_cnt, or when the FIFO is full.
//  Downstream
//   - m_valid = FIFO not empty; m_meas/m_idx = FIFO head, stable while m_valid && !m_ready.
//   - A pop on m_valid && m_ready increments tx_cnt.
//   - Simultaneous push and pop is legal at any fill level, including full; fifo_cnt is unchanged.
//  Arithmetic
//   - Counters are $clog2(N_SIGMA+1) bits and never wrap within a batch.
//   - FIFO pointers are $clog2(BUF_DEPTH)+1 bits and wrap naturally.
//  Latency
//   - Upstream transfer to pe_state_valid: 1 cycle.
//   - pe_meas_valid to m_valid: 1 cycle (registered FIFO count).
// TESTING
//  PE stub: fixed PE_LATENCY; pe_meas = {state[159:128], state[31:0]}.
//  1) After rst, FLUSH: stub injects pe_meas_valid at cycle 5 of FLUSH -> no push, err=0.
//     IDLE is reached after PE_LATENCY+2 cycles.
//  2) start, then 11 points with sp[159:128]=k and sp[31:0]=32'hffff_f1fe, sp_valid held, m_ready=1
//     -> sp_ready held 11 cycles; m_idx 0..10; m_meas=={k, 32'hffff_f1fe}; done once; busy falls next cycle.
//  3) m_ready=0 for the whole batch, BUF_DEPTH=4
//     -> sp_ready drops after 4 issues; no err. Releasing m_ready completes all 11 in order.
//  4) m_ready toggled every cycle, sp_valid random 50%
//     -> output sequence and indices identical to case 2; m_meas stable while stalled.
//  5) rst asserted at issue 6 -> outputs reset, no done. The 6 in-flight results are dropped in FLUSH.
//     A following batch returns indices 0..10 with err=0.
//  6) Stub pulses pe_meas_valid in IDLE -> err=1 and stays 1 until rst; FIFO stays empty.

Source files
------------

// File: rtl/pe_meas_sched.sv
// ---------------------------------------------------------------------------
// pe_meas_sched
//
// Purpose
//   Streams one batch of N_SIGMA sigma points (160-bit, 5 x Q16.16) through a
//   single fixed-latency measurement PE. The results come back in order as
//   64-bit {range, bearing} words, each tagged with its sigma-point index.
//   The PE cannot be stalled, so upstream issue is limited by credits against
//   the result FIFO. After every reset a flush window swallows any results
//   still in the PE pipeline from before the reset.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               batch start pulse (only honoured in IDLE)
//   busy / done / err   status: not-idle, end-of-batch pulse, sticky PE error
//   sp_state/valid/ready  upstream sigma-point handshake
//   pe_en_clk           PE clock enable
//   pe_state/valid      registered PE input
//   pe_meas/valid       PE result {range[63:32], bearing[31:0]}
//   m_meas/m_idx/m_valid/m_ready  downstream measurement handshake (FIFO head)
// ---------------------------------------------------------------------------
module pe_meas_sched #(
    parameter int N_SIGMA    = 11,
    parameter int PE_LATENCY = 24,
    parameter int BUF_DEPTH  = 16,
    localparam int IW        = $clog2(N_SIGMA)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           err,
    input  logic [159:0]   sp_state,
    input  logic           sp_valid,
    output logic           sp_ready,
    output logic           pe_en_clk,
    output logic [159:0]   pe_state,
    output logic           pe_state_valid,
    input  logic [63:0]    pe_meas,
    input  logic           pe_meas_valid,
    output logic [63:0]    m_meas,
    output logic [IW-1:0]  m_idx,
    output logic           m_valid,
    input  logic           m_ready
);

    localparam int CW = $clog2(N_SIGMA + 1);       // batch counters
    localparam int AW = $clog2(BUF_DEPTH);         // FIFO address
    localparam int PW = AW + 1;                    // FIFO pointers (extra wrap bit)
    localparam int FW = $clog2(PE_LATENCY + 2);    // flush counter
    localparam int SW = ((CW > PW) ? CW : PW) + 1; // occupancy sum
    localparam int DW = 64 + IW;                   // FIFO entry: {idx, meas}

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            err_q;
    logic [159:0]    pe_state_q;
    logic            pe_state_valid_q;

    logic [DW-1:0]   fifo_mem [BUF_DEPTH];

    // ------------------------------------------------------------------
    // FIFO status and credit computation
    // ------------------------------------------------------------------
    logic [PW-1:0]   fifo_cnt;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   inflight;
    logic [SW-1:0]   occupancy;
    logic            credit_ok;
    logic            rx_state;
    logic            xfer;
    logic            pop;
    logic            push;
    logic            err_set;
    logic [DW-1:0]   head;

    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == PW'(BUF_DEPTH));

    // Every issued point reserves a FIFO slot until it is popped, so the PE
    // can never deliver a result that has nowhere to go.
    assign inflight   = issue_cnt_q - rx_cnt_q;
    assign occupancy  = SW'(inflight) + SW'(fifo_cnt);
    assign credit_ok  = (occupancy < SW'(BUF_DEPTH));

    assign sp_ready   = (state_q == ST_ISSUE)
                      && (issue_cnt_q < CW'(N_SIGMA))
                      && credit_ok;
    assign xfer       = sp_valid && sp_ready;

    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;

    // Results are only expected while a batch is in flight. A same-cycle pop
    // frees a slot, so a push into a full FIFO is still fine then.
    assign rx_state   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign push       = rx_state && pe_meas_valid
                      && (rx_cnt_q != issue_cnt_q)
                      && (!fifo_full || pop);

    // FLUSH deliberately ignores pe_meas_valid: stale pre-reset results.
    assign err_set    = pe_meas_valid
                      && ((state_q == ST_IDLE) || (state_q == ST_DONE)
                          || (rx_state && !push));

    // ------------------------------------------------------------------
    // FSM: next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        issue_cnt_d = issue_cnt_q + CW'(xfer);
        rx_cnt_d    = rx_cnt_q + CW'(push);
        tx_cnt_d    = tx_cnt_q + CW'(pop);
        busy        = 1'b1;
        done        = 1'b0;
        pe_en_clk   = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                pe_en_clk = 1'b1;
                if (flush_cnt_q == FW'(PE_LATENCY + 1)) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d     = ST_ISSUE;
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                    tx_cnt_d    = '0;
                end
            end
            ST_ISSUE: begin
                pe_en_clk = 1'b1;
                if (issue_cnt_q == CW'(N_SIGMA)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pe_en_clk = 1'b1;
                if (tx_cnt_q == CW'(N_SIGMA)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, pointers, PE input register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_FLUSH;
            flush_cnt_q      <= '0;
            issue_cnt_q      <= '0;
            rx_cnt_q         <= '0;
            tx_cnt_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            err_q            <= 1'b0;
            pe_state_q       <= '0;
            pe_state_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            issue_cnt_q      <= issue_cnt_d;
            rx_cnt_q         <= rx_cnt_d;
            tx_cnt_q         <= tx_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            pe_state_valid_q <= xfer;
            if (xfer) begin
                pe_state_q <= sp_state;
            end
        end
    end

    // Storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {rx_cnt_q[IW-1:0], pe_meas};
        end
    end

    // The head is read combinationally so it is visible in the same cycle
    // the registered count first shows the entry (one-cycle result latency).
    // It is masked while empty so the outputs read zero out of reset.
    assign head   = fifo_mem[rd_ptr_q[AW-1:0]];
    assign m_meas = m_valid ? head[63:0] : 64'd0;
    assign m_idx  = m_valid ? head[DW-1:64] : '0;

    assign err            = err_q;
    assign pe_state       = pe_state_q;
    assign pe_state_valid = pe_state_valid_q;

endmodule

// File: tb/tb_pe_meas_sched.sv
// ---------------------------------------------------------------------------
// tb_pe_meas_sched
//
// Two scheduler instances share one stimulus set: instance 0 has a 16-entry
// result buffer, instance 1 a 4-entry buffer. 'sel' routes start / sp_valid /
// m_ready to one instance and picks which one the monitor observes. Each
// instance has a fixed-latency PE stub returning {state[159:128], state[31:0]}.
// Stimulus pushes the expected {idx, meas} into a queue at every upstream
// transfer; an independent monitor pops and compares on each downstream pop.
// ---------------------------------------------------------------------------
module tb_pe_meas_sched;

    localparam int N = 11;
    localparam int L = 24;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sp_valid = 1'b0;
    logic         m_ready = 1'b0;
    logic [159:0] sp_state = '0;
    logic         sel = 1'b0;
    logic [1:0]   inj = 2'b00;

    logic [1:0]   busy, done, err, sp_ready, pe_en_clk, pe_state_valid, pe_meas_valid, m_valid;
    logic [159:0] pe_state [2];
    logic [63:0]  pe_meas  [2];
    logic [63:0]  m_meas   [2];
    logic [3:0]   m_idx    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic        start_g, sp_valid_g, m_ready_g;
        logic        pipe_v [L];
        logic [63:0] pipe_d [L];

        assign start_g    = start    && (sel == gi[0]);
        assign sp_valid_g = sp_valid && (sel == gi[0]);
        assign m_ready_g  = m_ready  && (sel == gi[0]);

        initial begin
            for (int j = 0; j < L; j++) begin
                pipe_v[j] = 1'b0;
                pipe_d[j] = '0;
            end
        end

        // PE stub: keeps running through reset so in-flight results surface in FLUSH.
        always @(posedge clk) begin
            pipe_v[0] <= pe_state_valid[gi];
            pipe_d[0] <= {pe_state[gi][159:128], pe_state[gi][31:0]};
            for (int j = 1; j < L; j++) begin
                pipe_v[j] <= pipe_v[j-1];
                pipe_d[j] <= pipe_d[j-1];
            end
        end

        assign pe_meas_valid[gi] = pipe_v[L-1] || inj[gi];
        assign pe_meas[gi]       = pipe_d[L-1];

        pe_meas_sched #(
            .N_SIGMA    (N),
            .PE_LATENCY (L),
            .BUF_DEPTH  ((gi == 0) ? 16 : 4)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start_g),
            .busy           (busy[gi]),
            .done           (done[gi]),
            .err            (err[gi]),
            .sp_state       (sp_state),
            .sp_valid       (sp_valid_g),
            .sp_ready       (sp_ready[gi]),
            .pe_en_clk      (pe_en_clk[gi]),
            .pe_state       (pe_state[gi]),
            .pe_state_valid (pe_state_valid[gi]),
            .pe_meas        (pe_meas[gi]),
            .pe_meas_valid  (pe_meas_valid[gi]),
            .m_meas         (m_meas[gi]),
            .m_idx          (m_idx[gi]),
            .m_valid        (m_valid[gi]),
            .m_ready        (m_ready_g)
        );
    end

    // Views of the selected instance
    logic         busy_s, done_s, err_s, sp_ready_s, pe_en_s, pev_s, m_valid_s;
    logic [63:0]  m_meas_s;
    logic [3:0]   m_idx_s;
    assign busy_s     = busy[sel];
    assign done_s     = done[sel];
    assign err_s      = err[sel];
    assign sp_ready_s = sp_ready[sel];
    assign pe_en_s    = pe_en_clk[sel];
    assign pev_s      = pe_state_valid[sel];
    assign m_valid_s  = m_valid[sel];
    assign m_meas_s   = m_meas[sel];
    assign m_idx_s    = m_idx[sel];

    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           last_sprdy = 0;
    logic [67:0]  exp_q [$];

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        sp_valid = 1'b0;
        tick();
        rst      = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        logic        stall;
        logic [67:0] held;
        logic [67:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (done_s) done_cnt++;
            if (m_valid_s) begin
                if (stall) check("hold_while_stalled", {m_idx_s, m_meas_s}, held);
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop: got %0h expected nothing", {m_idx_s, m_meas_s});
                    end else begin
                        e = exp_q.pop_front();
                        $display("pop idx=%0d meas=%h", m_idx_s, m_meas_s);
                        check("pop_data", {m_idx_s, m_meas_s}, e);
                    end
                end
                stall = !m_ready;
                held  = {m_idx_s, m_meas_s};
            end else begin
                stall = 1'b0;
            end
        end
    end

    // vmode: 0 = sp_valid held, 1 = random 50%
    // rmode: 0 = m_ready high, 1 = low until cycle 80, 2 = toggling
    // abort_at: stop after this many transfers (0 = run to done)
    task automatic run_batch(input int vmode, input int rmode, input int abort_at);
        int   k, cyc, sprdy, d0;
        logic xfer;
        k = 0; cyc = 0; sprdy = 0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (1) begin
            if (done_cnt != d0) break;
            if (abort_at > 0 && k == abort_at) break;
            if (cyc >= 3000) begin
                checks++;
                errors++;
                $display("FAIL batch_timeout: got %0d issued after %0d cycles expected done", k, cyc);
                break;
            end
            sp_state = {32'(k), 96'h0, 32'hffff_f1fe};
            sp_valid = (k < N) && (vmode == 0 || $urandom_range(0, 1) == 1);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc >= 80);
                default: m_ready = cyc[0];
            endcase
            if (rmode == 1 && cyc == 79) begin
                check("credit_stall_issues", 68'(k), 68'd4);
                check("credit_stall_err", 68'(err_s), 68'd0);
            end
            @(negedge clk);
            xfer = sp_valid && sp_ready_s;
            if (sp_ready_s) sprdy++;
            tick();
            if (xfer) begin
                exp_q.push_back({4'(k), 32'(k), 32'hffff_f1fe});
                $display("issue idx=%0d", k);
                k++;
            end
            cyc++;
        end
        sp_valid   = 1'b0;
        last_sprdy = sprdy;
        if (abort_at == 0) begin
            @(negedge clk);
            check("busy_after_done", 68'(busy_s), 68'd0);
            repeat (3) tick();
            check("done_pulses", 68'(done_cnt - d0), 68'd1);
            check("all_popped", 68'(exp_q.size()), 68'd0);
            check("batch_err", 68'(err_s), 68'd0);
        end
    endtask

    initial begin
        int d_before;

        // 1) reset values and flush window
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        check("rst_busy", 68'(busy_s), 68'd1);
        check("rst_pe_en", 68'(pe_en_s), 68'd1);
        check("rst_pe_valid", 68'(pev_s), 68'd0);
        check("rst_m_valid", 68'(m_valid_s), 68'd0);
        check("rst_m_meas", {m_idx_s, m_meas_s}, 68'd0);
        check("rst_sp_ready", 68'(sp_ready_s), 68'd0);
        check("rst_done", 68'(done_s), 68'd0);
        check("rst_err", 68'(err_s), 68'd0);
        repeat (5) tick();
        inj = 2'b01;
        tick();
        inj = 2'b00;
        repeat (19) tick();
        @(negedge clk);
        check("flush_last_cycle_busy", 68'(busy_s), 68'd1);
        tick();
        @(negedge clk);
        check("idle_busy", 68'(busy_s), 68'd0);
        check("idle_pe_en", 68'(pe_en_s), 68'd0);
        check("flush_inject_err", 68'(err_s), 68'd0);
        check("flush_inject_m_valid", 68'(m_valid_s), 68'd0);

        // 2) back-to-back batch
        tick();
        run_batch(0, 0, 0);
        check("sp_ready_cycles", 68'(last_sprdy), 68'd11);

        // 4) random upstream valid, toggling downstream ready
        run_batch(1, 2, 0);

        // 3) 4-entry buffer, downstream stalled then released
        sel = 1'b1;
        tick();
        run_batch(0, 1, 0);
        sel = 1'b0;
        tick();

        // 5) reset mid-batch after 6 issues
        d_before = done_cnt;
        run_batch(0, 0, 6);
        do_reset();
        exp_q.delete();
        repeat (28) tick();
        @(negedge clk);
        check("abort_no_done", 68'(done_cnt - d_before), 68'd0);
        check("abort_err", 68'(err_s), 68'd0);
        check("abort_m_valid", 68'(m_valid_s), 68'd0);
        check("abort_idle", 68'(busy_s), 68'd0);
        tick();
        run_batch(0, 0, 0);

        // 6) stray PE result in IDLE
        inj = 2'b01;
        tick();
        inj = 2'b00;
        tick();
        @(negedge clk);
        check("idle_inject_err", 68'(err_s), 68'd1);
        check("idle_inject_m_valid", 68'(m_valid_s), 68'd0);
        repeat (10) tick();
        check("err_sticky", 68'(err_s), 68'd1);
        do_reset();
        @(negedge clk);
        check("err_cleared_by_rst", 68'(err_s), 68'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1, "watchdog");
    end

endmodule
